// File: rtl/dfs_pkg.sv
// dfs_pkg: FSM states and default table widths shared by the DFS table controller.
package dfs_pkg;
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, ISSUE, WAIT_DONE} dfs_state_t;
    localparam int DFS_ADDR_WIDTH = 10;
    localparam int DFS_DATA_WIDTH = 18;
endpackage

// File: rtl/dfs_rr_arbiter.sv
// dfs_rr_arbiter: round-robin pick, searching from one past the last grant.
module dfs_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);
    // scan farthest-first so the nearest requester after last overwrites
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--)
            if (req[(int'(last) + k) % N_REQ]) begin
                gnt = '0;
                gnt[(int'(last) + k) % N_REQ] = 1'b1;
                idx = IW'((int'(last) + k) % N_REQ);
            end
    end
endmodule

// File: rtl/dfs_lut_ctrl.sv
// dfs_lut_ctrl: arbitrates level-change requests, reads the frequency table and
// hands the configuration word to the clock generator, then waits for relock.
module dfs_lut_ctrl
    import dfs_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = DFS_ADDR_WIDTH,
    parameter int DATA_WIDTH = DFS_DATA_WIDTH,
    parameter int TIMEOUT    = 1023,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [ADDR_WIDTH-1:0]       rom_addr_o,
    output logic                        rom_valid_o,
    input  logic [DATA_WIDTH-1:0]       rom_data_i,
    output logic                        cfg_valid_o,
    output logic [DATA_WIDTH-1:0]       cfg_data_o,
    input  logic                        cfg_ready_i,
    input  logic                        cfg_done_i,
    output logic                        busy_o,
    output logic [IW-1:0]               grant_id_o,
    output logic [ADDR_WIDTH-1:0]       cur_addr_o,
    output logic                        err_o
);
    dfs_state_t            state, state_nxt;
    logic [N_REQ-1:0]      gnt;
    logic [IW-1:0]         gnt_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [CW-1:0]         cnt;
    logic                  applied, any_req, hit, tmo;

    dfs_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req  (req_valid_i),
        .last (grant_id_o),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    // rom_addr_o doubles as the latched address of the transaction in flight
    assign any_req     = |req_valid_i;
    assign sel_addr    = req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit         = applied && sel_addr == cur_addr_o;
    assign tmo         = cnt == CW'(TIMEOUT - 1);
    assign req_ready_o = (state == IDLE && !reset) ? gnt : '0;
    assign rom_valid_o = state == READ;
    assign cfg_valid_o = state == ISSUE;
    assign busy_o      = state != IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = (any_req && !hit) ? READ : IDLE;
            READ:      state_nxt = CAPTURE;
            CAPTURE:   state_nxt = ISSUE;
            ISSUE:     state_nxt = cfg_ready_i ? WAIT_DONE : ISSUE;
            WAIT_DONE: state_nxt = (cfg_done_i || tmo) ? IDLE : WAIT_DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_o <= '0;
            cfg_data_o <= '0;
            grant_id_o <= IW'(N_REQ - 1);
            cur_addr_o <= '0;
            applied    <= 1'b0;
            err_o      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id_o <= gnt_idx;
                if (!hit) rom_addr_o <= sel_addr;
            end
            if (state == CAPTURE) cfg_data_o <= rom_data_i;
            cnt <= (state == WAIT_DONE && !cfg_done_i && !tmo) ? cnt + CW'(1) : '0;
            // a relock on the final counted cycle still beats the timeout
            if (state == WAIT_DONE && cfg_done_i) begin
                cur_addr_o <= rom_addr_o;
                applied    <= 1'b1;
            end else if (state == WAIT_DONE && tmo) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule
